// File: rtl/demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Optional broadcast routing is enabled with the DEMUX_BROADCAST_EN macro.
package demux_pkg;

    // Occupancy of one lane holding register.
    typedef enum logic {
        LANE_EMPTY,
        LANE_FULL
    } lane_state_t;

    // Number of output lanes addressed by a select_width-bit lane index.
    function automatic int lanes(input int select_width);
        return 1 << select_width;
    endfunction

endpackage

// File: rtl/stream_demultiplexer_if.sv
// Handshake bundle for the stream demultiplexer: one valid/ready input stream
// tagged with a lane index, and LANES independent valid/ready output lanes.
// The in_broadcast signal exists only when DEMUX_BROADCAST_EN is defined.
interface stream_demultiplexer_if #(
    parameter int WIDTH        = 5,
    parameter int SELECT_WIDTH = 2
);
    import demux_pkg::*;

    localparam int LANES = lanes(SELECT_WIDTH);

`ifdef DEMUX_BROADCAST_EN
    logic                         in_broadcast;
`endif
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             in_data;
    logic [SELECT_WIDTH-1:0]      in_index;
    logic [LANES-1:0]             out_valid;
    logic [LANES-1:0]             out_ready;
    logic [LANES-1:0][WIDTH-1:0]  out_data;

    // Producer and consumers: drive words in, take words out.
    modport master (
`ifdef DEMUX_BROADCAST_EN
        output in_broadcast,
`endif
        output in_valid,
        input  in_ready,
        output in_data,
        output in_index,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    // The demultiplexer itself.
    modport slave (
`ifdef DEMUX_BROADCAST_EN
        input  in_broadcast,
`endif
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_index,
        output out_valid,
        input  out_ready,
        output out_data
    );

endinterface

// File: rtl/demux_lane.sv
// One-entry register slice for a single output lane. A write while the
// consumer takes the current word replaces it in place, so a draining lane
// accepts one word per cycle with no bubble.
module demux_lane
    import demux_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,    // load wr_data this edge (only when free)
    input  logic [WIDTH-1:0] wr_data,
    input  logic             take,     // consumer ready for this lane
    output logic             free,     // a write would be accepted this cycle
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    lane_state_t state_q;
    lane_state_t state_d;

    // Lane occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state_q <= LANE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy: fill on write, empty only on a take without a refill.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch
        // is inferred.
        state_d = state_q;
        unique case (state_q)
            LANE_EMPTY: if (wr_en)          state_d = LANE_FULL;
            LANE_FULL:  if (take && !wr_en) state_d = LANE_EMPTY;
            default:                        state_d = LANE_EMPTY;
        endcase
    end

    // Holding register; keeps its value while empty or stalled.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the data register is reset too, because the lane output
        // must read zero while reset is asserted.
        if (reset) begin
            data <= '0;
        end else if (wr_en) begin
            data <= wr_data;
        end
    end

    assign valid = (state_q == LANE_FULL);
    assign free  = !valid || take;

endmodule

// File: rtl/stream_demultiplexer.sv
// Stream demultiplexer: routes each accepted input word to the lane named by
// in_index (or to every lane when in_broadcast is set and DEMUX_BROADCAST_EN
// is defined). Each lane is an independent one-entry slice, so a stalled lane
// only blocks words addressed to it. in_ready depends combinationally on
// out_ready of the addressed lane(s).
module stream_demultiplexer
    import demux_pkg::*;
#(
    parameter int WIDTH        = 5,
    parameter int SELECT_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    stream_demultiplexer_if.slave bus
);

    localparam int LANES = lanes(SELECT_WIDTH);

    logic [LANES-1:0]            lane_free;
    logic [LANES-1:0]            lane_valid;
    logic [LANES-1:0][WIDTH-1:0] lane_data;
    logic [LANES-1:0]            load_mask;
    logic [LANES-1:0]            wr_en;
    logic                        ready;

    // Index decode and in_ready selection; a broadcast needs every lane free
    // so that all lanes load on the same edge or none do.
    always_comb begin
        load_mask                = '0;
        load_mask[bus.in_index]  = 1'b1;
        ready                    = lane_free[bus.in_index];
`ifdef DEMUX_BROADCAST_EN
        if (bus.in_broadcast) begin
            load_mask = '1;
            ready     = &lane_free;
        end
`endif
        ready = ready && !reset;
        wr_en = (bus.in_valid && ready) ? load_mask : '0;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        demux_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[i]),
            .wr_data (bus.in_data),
            .take    (bus.out_ready[i]),
            .free    (lane_free[i]),
            .valid   (lane_valid[i]),
            .data    (lane_data[i])
        );
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = lane_valid;
    assign bus.out_data  = lane_data;

endmodule
